// File: rtl/update_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : upd_sched_pkg
// Brief    : Shared types, defaults and round-robin helper for update_scheduler
// Revision : 1.0 - initial release
// ============================================================================
package upd_sched_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_W     = 8;
  localparam int DEF_DEPTH = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_e;

  typedef logic [$clog2(DEF_NREQ)-1:0] req_idx_t;

  function automatic int next_rr(input int ptr, input int nreq);
    return (ptr + 1 >= nreq) ? 0 : ptr + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/update_scheduler_queue.sv
`default_nettype none
// ============================================================================
// Module   : upd_queue
// Brief    : DEPTH x W synchronous FIFO with wrap-bit pointers and level output
// Revision : 1.0 - initial release
// ============================================================================
module upd_queue
  import upd_sched_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok;
  logic         pop_ok;

  // Pointers carry one extra wrap bit: equal -> empty, only MSB differs -> full.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : update_scheduler
// Brief    : Round-robin serialisation of per-requester FIFO updates onto w_q
// Revision : 1.0 - initial release
// ============================================================================
module update_scheduler
  import upd_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [W-1:0]             w_q,
  output logic                     w_update,
  output logic [$clog2(NREQ)-1:0]  w_src,
  output logic                     settled
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int LW    = $clog2(DEPTH) + 1;

  logic [NREQ-1:0]  push_vec;
  logic [NREQ-1:0]  pop_vec;
  logic [NREQ-1:0]  full_vec;
  logic [NREQ-1:0]  empty_vec;
  logic [W-1:0]     dout_arr  [NREQ];
  logic [LW-1:0]    level_arr [NREQ];

  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             pending;
  int               idx;

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [W-1:0]     w_d;
  logic [IDX_W-1:0] w_src_q, w_src_d;
  logic             w_update_q, w_update_d;

  for (genvar i = 0; i < NREQ; i++) begin : g_queue
    upd_queue #(
      .DEPTH (DEPTH),
      .W     (W)
    ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push_vec[i]),
      .pop   (pop_vec[i]),
      .din   (req_data[i*W +: W]),
      .dout  (dout_arr[i]),
      .full  (full_vec[i]),
      .empty (empty_vec[i]),
      .level (level_arr[i])
    );
  end

  assign req_ready = ~full_vec;
  assign push_vec  = req_valid & ~full_vec;

  // Scan from rr_ptr upward, wrapping, for the first queue holding an entry.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_valid && !empty_vec[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    pop_vec = '0;
    pending = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pop_vec[i] = grant_valid && (grant_idx == IDX_W'(i));
      if (push_vec[i] || (level_arr[i] > LW'(pop_vec[i]))) pending = 1'b1;
    end
  end

  // Stays BUSY while anything remains queued after this edge; IDLE otherwise.
  always_comb begin
    state_d    = pending ? BUSY : IDLE;
    rr_ptr_d   = rr_ptr_q;
    w_d        = w_q;
    w_src_d    = w_src_q;
    w_update_d = 1'b0;
    if (grant_valid) begin
      w_d        = dout_arr[grant_idx];
      w_src_d    = grant_idx;
      w_update_d = 1'b1;
      rr_ptr_d   = IDX_W'(next_rr(int'(grant_idx), NREQ));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      w_q        <= '0;
      w_src_q    <= '0;
      w_update_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      w_q        <= w_d;
      w_src_q    <= w_src_d;
      w_update_q <= w_update_d;
    end
  end

  assign w_update = w_update_q;
  assign w_src    = w_src_q;
  assign settled  = (state_q == IDLE);

  a_settled_empty: assert property (@(posedge clk) disable iff (rst)
    settled |-> (&empty_vec));

  a_update_src: assert property (@(posedge clk) disable iff (rst)
    w_update |-> ($past(grant_idx) == w_src) && !$past(empty_vec[grant_idx]));

endmodule
`default_nettype wire

// File: tb/tb_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_update_scheduler
// Brief    : Scoreboard bench: queue-level reference model, decoupled monitor
// Revision : 1.0 - initial release
// ============================================================================
module tb_update_scheduler;

  localparam int NREQ  = 4;
  localparam int W     = 8;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      w_q;
  logic              w_update;
  logic [1:0]        w_src;
  logic              settled;

  update_scheduler #(
    .NREQ  (NREQ),
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .w_q       (w_q),
    .w_update  (w_update),
    .w_src     (w_src),
    .settled   (settled)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   src;
    logic [W-1:0] data;
  } commit_t;

  commit_t      sb[$];
  logic [W-1:0] mq[NREQ][$];
  int           rr_m;
  logic         exp_settled;
  logic [W-1:0] model_last;
  logic [W-1:0] mon_last;
  int           checks;
  int           errors;
  bit           done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ*W-1:0] pk(input logic [W-1:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  // One clock of stimulus; the model applies the same edge at queue level.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] d,
                      output logic [NREQ-1:0] acc);
    logic [NREQ-1:0] rdy;
    int g;
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    for (int i = 0; i < NREQ; i++) rdy[i] = (mq[i].size() < DEPTH);
    #1;
    chk("req_ready", 32'(req_ready), 32'(rdy));
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (rr_m + k) % NREQ;
      if (g < 0 && mq[j].size() > 0) g = j;
    end
    if (g >= 0) begin
      sb.push_back({2'(g), mq[g][0]});
      model_last = mq[g][0];
      void'(mq[g].pop_front());
      rr_m = (g + 1) % NREQ;
    end
    acc = v & rdy;
    for (int i = 0; i < NREQ; i++) if (acc[i]) mq[i].push_back(d[i*W +: W]);
    exp_settled = 1'b1;
    for (int i = 0; i < NREQ; i++) if (mq[i].size() != 0) exp_settled = 1'b0;
  endtask

  task automatic idle(input int n);
    logic [NREQ-1:0] a;
    for (int i = 0; i < n; i++) step('0, '0, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_w_q", 32'(w_q), 32'h0);
    chk("rst_w_update", 32'(w_update), 32'h0);
    chk("rst_w_src", 32'(w_src), 32'h0);
    chk("rst_settled", 32'(settled), 32'h1);
    chk("rst_req_ready", 32'(req_ready), 32'hF);
    for (int i = 0; i < NREQ; i++) mq[i].delete();
    sb.delete();
    rr_m        = 0;
    exp_settled = 1'b1;
    model_last  = '0;
    mon_last    = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every commit pulse the DUT shows.
  initial begin
    commit_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (!rst) begin
        chk("settled", 32'(settled), 32'(exp_settled));
        if (w_update) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_commit: got w_src=%0d w_q=%0h expected no commit", w_src, w_q);
          end else begin
            e = sb.pop_front();
            chk("w_src", 32'(w_src), 32'(e.src));
            chk("w_q", 32'(w_q), 32'(e.data));
            mon_last = e.data;
          end
        end else begin
          chk("w_q_hold", 32'(w_q), 32'(mon_last));
        end
      end
    end
  end

  initial begin
    logic [NREQ-1:0] a;
    int got;
    rst = 1'b1; req_valid = '0; req_data = '0;
    rr_m = 0; exp_settled = 1'b1; model_last = '0; mon_last = '0;
    checks = 0; errors = 0; done = 1'b0;
    do_reset();

    // Single requester back-to-back, later value wins
    step(4'b0001, pk(8'h00, 0, 0, 0), a);
    step(4'b0001, pk(8'h01, 0, 0, 0), a);
    idle(4);
    chk("t1_w_q", 32'(w_q), 32'h01);
    chk("t1_settled", 32'(settled), 32'h1);

    // All four at once from rr_ptr=0
    do_reset();
    step(4'b1111, pk(8'd10, 8'd11, 8'd12, 8'd13), a);
    idle(6);
    chk("t2_w_q", 32'(w_q), 32'd13);

    // Requester 2 backs up behind 0 and 1
    step(4'b0111, pk(8'h20, 8'h21, 8'h30, 0), a);
    got = a[2] ? 1 : 0;
    step(4'b0111, pk(8'h22, 8'h23, 8'h31, 0), a);
    if (a[2]) got++;
    for (int n = 0; n < 10 && got < 3; n++) begin
      step(4'b0100, pk(0, 0, 8'h30 + 8'(got), 0), a);
      if (a[2]) got++;
    end
    chk("t3_accepts", 32'(got), 32'd3);
    idle(8);
    chk("t3_w_q", 32'(w_q), 32'h32);

    // Wrap-around: rr_ptr reaches 3, then 3 and 0 pending
    do_reset();
    step(4'b0100, pk(0, 0, 8'h40, 0), a);
    step(4'b1001, pk(8'h41, 0, 0, 8'h43), a);
    idle(2);
    step(4'b0011, pk(8'h50, 8'h51, 0, 0), a);
    idle(4);
    chk("t4_w_q", 32'(w_q), 32'h50);

    // Async reset with three entries queued and w_q=5A
    do_reset();
    step(4'b0010, pk(0, 8'h5A, 0, 0), a);
    step(4'b1101, pk(8'h01, 0, 8'h02, 8'h03), a);
    @(posedge clk);
    #2;
    chk("t5_pre_w_q", 32'(w_q), 32'h5A);
    do_reset();
    idle(3);

    // Randomised burst
    for (int n = 0; n < 1000; n++) step(4'($urandom), NREQ*W'($urandom), a);
    idle(12);
    @(posedge clk);
    #2;
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_settled", 32'(settled), 32'h1);
    chk("final_w_q", 32'(w_q), 32'(model_last));
    done = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
